// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// fa_bit: combinational 1-bit full-adder cell shared across all bit positions.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB-first, one bit per clock.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` port for a - b (cout = no borrow).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sr_q;
  logic [WIDTH-1:0]   b_sr_q;
  logic [WIDTH-1:0]   res_sr_q;
  logic               c_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               s_c;
  logic               co_c;
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]   b_cap_c;
  logic               c_cap_c;

  fa_bit u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (c_q),
    .s  (s_c),
    .co (co_c)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    res_d            = res_sr_q >> 1;
    res_d[WIDTH-1]   = s_c;
  end

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1.
  assign b_cap_c = sub ? ~b : b;
  assign c_cap_c = sub ? 1'b1 : cin;
`else
  assign b_cap_c = b;
  assign c_cap_c = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b_cap_c;
            c_q     <= c_cap_c;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          c_q      <= co_c;
          res_sr_q <= res_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= res_d;
            cout    <= co_c;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer. It shares one 1-bit full-adder cell across a WIDTH-bit operation, processing bits LSB-first at one bit per clock with a registered carry. A start/busy/done handshake lets a lab-level top or CPU datapath issue multi-bit adds through a single adder resource.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-high
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  initial carry-in, captured on accepted start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse when result becomes valid
sum  output  WIDTH  registered result, stable between completions
cout  output  1  registered final carry-out

Behaviour:
- Single clock `clk`. Synchronous active-high reset `rst`.
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry reg and count cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accepted start: a_sr<=a, b_sr<=b, c_reg<=cin, cnt<=0, go RUN.
  - Otherwise hold.
- RUN (busy=1), every cycle:
  - s = a_sr[0]^b_sr[0]^c_reg
  - c_reg <= majority(a_sr[0], b_sr[0], c_reg)
  - a_sr, b_sr shift right.
  - s shifts into res_sr at the MSB.
  - cnt++.
  - When cnt==WIDTH-1 (last bit this cycle): go DONE.
- Entering DONE: sum<=final res_sr, cout<=final carry. DONE lasts one cycle with done=1, busy=0.
- DONE transitions:
  - start high in DONE: accepted same as IDLE (back-to-back, no bubble).
  - Otherwise go IDLE.
- Latency: start sampled at edge k; done high during cycle k+WIDTH+1 (WIDTH RUN cycles + DONE). sum/cout valid from that cycle.
- sum/cout update only at completion and hold until the next completion or reset. They never show partial results.
- start while busy=1: ignored, no queueing, no effect on the operation in progress.
- a/b/cin changes after capture: no effect.
- rst mid-RUN: abort. Next cycle IDLE, all outputs 0, the pending result is discarded.
- rst and start in the same cycle: rst wins.
- WIDTH=1: RUN lasts exactly one cycle. cnt compare must be correct for this case.
- Arithmetic is unsigned modulo 2^WIDTH; carry out of the MSB goes to cout only.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra port `sub` (input, 1), captured on accepted start.
  - When sub=1: b is captured inverted and c_reg is initialised to 1, ignoring cin. Result = a-b mod 2^WIDTH; cout=1 means no borrow (a>=b).
- Undefined:
  - No `sub` port; add-only behaviour as above. Port list and timing are otherwise identical.

Decomposition:
- Shared package serial_adder_pkg:
  - State encoding enum/localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- One natural sub-module: fa_bit, a purely combinational 1-bit full-adder cell (a, b, ci -> s, co), instantiated once. The controller holds all state.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start at cycle 0 -> busy cycles 1-8, done pulse at cycle 9 only, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start pulse with a=0x01, b=0x01 asserted at cycle 4 of a running 0x5A+0x3C -> ignored; first result 0x96. No second done until a new start in IDLE/DONE.
- Back-to-back: start held high in the DONE cycle with a=0x10, b=0x20 -> next done exactly 9 cycles later, sum=0x30. Previous sum 0x96 holds until then.
- rst asserted at cycle 3 of a run -> next cycle busy=0, done=0, sum=0, cout=0. No done pulse afterwards.
- WIDTH=1, all 8 (a,b,cin) combinations -> sum/cout match the full-adder truth table; done 2 cycles after each start. With SERIAL_ADDER_SUB_EN at WIDTH=8: 0x10-0x01 -> 0x0F, cout=1; 0x01-0x02 -> 0xFF, cout=0.
